// File: rtl/bridge_pkg.sv
// Shared encodings between the CPU data port and data_bridge: access sizes,
// exception codes, timer register map and timer FSM states.
package bridge_pkg;

    localparam int          DM_WORDS_DEFAULT   = 3072;
    localparam logic [31:0] TIMER_BASE_DEFAULT = 32'h0000_7F00;
    localparam logic [31:0] TIMER_WINDOW_BYTES = 32'd12;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [2:0] SEL_NONE  = 3'd0;
    localparam logic [2:0] SEL_WORD  = 3'd1;
    localparam logic [2:0] SEL_HALF  = 3'd2;
    localparam logic [2:0] SEL_HALFU = 3'd3;
    localparam logic [2:0] SEL_BYTE  = 3'd4;
    localparam logic [2:0] SEL_BYTEU = 3'd5;

    localparam logic [31:0] TMR_CTRL_OFS   = 32'd0;
    localparam logic [31:0] TMR_PRESET_OFS = 32'd4;
    localparam logic [31:0] TMR_COUNT_OFS  = 32'd8;

    // Register index is the byte offset divided by four.
    localparam logic [1:0] TREG_CTRL   = 2'd0;
    localparam logic [1:0] TREG_PRESET = 2'd1;
    localparam logic [1:0] TREG_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_LOAD = 2'd1,
        TS_CNT  = 2'd2,
        TS_INT  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/bridge_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, sequencing FSM
// and level interrupt.
//
// state   | meaning
// --------+-----------------------------------------------
// TS_IDLE | stopped, waiting for CTRL.EN
// TS_LOAD | copy PRESET into COUNT
// TS_CNT  | count down to zero while EN stays set
// TS_INT  | raise pending; reload or stop depending on MODE
module bridge_timer
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_reg,
    input  logic [31:0] wr_data,
    output logic [3:0]  ctrl,
    output logic [31:0] preset,
    output logic [31:0] count,
    output logic        irq
);

    timer_state_t state_q, state_d;
    logic         load_cnt, dec_cnt, set_pend, clr_en;
    logic         pending;
    logic         wr_ctrl, wr_preset;

    assign wr_ctrl   = wr_en && (wr_reg == TREG_CTRL);
    assign wr_preset = wr_en && (wr_reg == TREG_PRESET);
    assign irq       = pending & ctrl[3];

    always_comb begin
        state_d  = state_q;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        set_pend = 1'b0;
        clr_en   = 1'b0;
        case (state_q)
            TS_IDLE: begin
                if (ctrl[0]) state_d = TS_LOAD;
            end
            TS_LOAD: begin
                load_cnt = 1'b1;
                state_d  = TS_CNT;
            end
            TS_CNT: begin
                if (!ctrl[0])            state_d = TS_IDLE;
                else if (count == 32'd0) state_d = TS_INT;
                else                     dec_cnt = 1'b1;
            end
            TS_INT: begin
                set_pend = 1'b1;
                // Only MODE 01 reloads; 10 and 11 fall back to one-shot.
                if (ctrl[2:1] == 2'b01) begin
                    state_d = TS_LOAD;
                end else begin
                    clr_en  = 1'b1;
                    state_d = TS_IDLE;
                end
            end
            default: state_d = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TS_IDLE;
            ctrl    <= 4'd0;
            preset  <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            state_q <= state_d;

            // A CPU write to CTRL takes priority over the one-shot EN clear.
            if (wr_ctrl)     ctrl    <= wr_data[3:0];
            else if (clr_en) ctrl[0] <= 1'b0;

            if (wr_preset) preset <= wr_data;

            if (load_cnt)     count <= preset;
            else if (dec_cnt) count <= count - 32'd1;

            if (set_pend)                   pending <= 1'b1;
            else if (wr_ctrl || wr_preset)  pending <= 1'b0;
        end
    end

endmodule

// File: rtl/data_bridge.sv
// Responder for the CPU data port: address decode and exception code, byte-lane
// steering, load extension, data RAM and the timer register window.
module data_bridge
    import bridge_pkg::*;
#(
    parameter int          DM_WORDS   = DM_WORDS_DEFAULT,
    parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic        m_data_mem_write,
    input  logic [2:0]  m_data_sel,
    input  logic        m_data_req,
    output logic [31:0] m_data_rdata,
    output logic [4:0]  m_data_exc,
    output logic        timer_irq
);

    localparam int          RAM_AW    = $clog2(DM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DM_WORDS);

    logic              access, is_word, is_half, is_byte;
    logic              misaligned, in_ram, in_tmr, tmr_bad, bad;
    logic              commit, ram_we, tmr_we;
    logic [31:0]       tmr_ofs;
    logic [1:0]        tmr_reg;
    logic [RAM_AW-1:0] ram_idx;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       word_rd, tmr_word, shifted, load_val;
    logic [3:0]        tmr_ctrl;
    logic [31:0]       tmr_preset, tmr_count;

    logic [31:0] ram [DM_WORDS];

    assign access  = (m_data_sel >= SEL_WORD) && (m_data_sel <= SEL_BYTEU);
    assign is_word = (m_data_sel == SEL_WORD);
    assign is_half = (m_data_sel == SEL_HALF) || (m_data_sel == SEL_HALFU);
    assign is_byte = (m_data_sel == SEL_BYTE) || (m_data_sel == SEL_BYTEU);

    assign misaligned = (is_word && (m_data_addr[1:0] != 2'b00)) ||
                        (is_half && m_data_addr[0]);
    assign in_ram     = (m_data_addr < RAM_BYTES);
    assign tmr_ofs    = m_data_addr - TIMER_BASE;
    assign in_tmr     = (tmr_ofs < TIMER_WINDOW_BYTES);
    assign tmr_reg    = tmr_ofs[3:2];
    // COUNT is read-only, and the timer only accepts whole-word accesses.
    assign tmr_bad    = in_tmr && (!is_word || (m_data_mem_write && tmr_reg == TREG_COUNT));
    assign bad        = misaligned || (!in_ram && !in_tmr) || tmr_bad;

    assign m_data_exc = (access && bad) ? (m_data_mem_write ? EXC_ADES : EXC_ADEL) : EXC_NONE;

    assign commit = access && m_data_mem_write && !bad && !m_data_req;
    assign ram_we = commit && in_ram;
    assign tmr_we = commit && in_tmr;

    assign ram_idx = m_data_addr[RAM_AW+1:2];

    always_comb begin
        be    = 4'b0000;
        wlane = m_data_wdata;
        if (is_word) begin
            be    = 4'b1111;
            wlane = m_data_wdata;
        end else if (is_half) begin
            be    = m_data_addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{m_data_wdata[15:0]}};
        end else if (is_byte) begin
            be    = 4'b0001 << m_data_addr[1:0];
            wlane = {4{m_data_wdata[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[ram_idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    bridge_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tmr_we),
        .wr_reg  (tmr_reg),
        .wr_data (m_data_wdata),
        .ctrl    (tmr_ctrl),
        .preset  (tmr_preset),
        .count   (tmr_count),
        .irq     (timer_irq)
    );

    always_comb begin
        tmr_word = 32'd0;
        case (tmr_reg)
            TREG_CTRL:   tmr_word = {28'd0, tmr_ctrl};
            TREG_PRESET: tmr_word = tmr_preset;
            TREG_COUNT:  tmr_word = tmr_count;
            default:     tmr_word = 32'd0;
        endcase
    end

    assign word_rd = in_tmr ? tmr_word : ram[ram_idx];
    // Alignment is already enforced, so a right shift by the byte offset
    // brings the addressed lane down to bit 0 for every access size.
    assign shifted = word_rd >> {m_data_addr[1:0], 3'b000};

    always_comb begin
        load_val = 32'd0;
        case (m_data_sel)
            SEL_WORD:  load_val = shifted;
            SEL_HALF:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            SEL_HALFU: load_val = {16'd0, shifted[15:0]};
            SEL_BYTE:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            SEL_BYTEU: load_val = {24'd0, shifted[7:0]};
            default:   load_val = 32'd0;
        endcase
    end

    assign m_data_rdata = (access && !bad && !m_data_mem_write) ? load_val : 32'd0;

endmodule

// File: tb/tb_data_bridge.sv
// Directed scoreboard bench for data_bridge: RAM lanes, decode exceptions and
// the timer sequences, with a negedge monitor popping expected responses.
module tb_data_bridge;
    import bridge_pkg::*;

    localparam logic [31:0] A_CTRL = 32'h0000_7F00;
    localparam logic [31:0] A_PRE  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT  = 32'h0000_7F08;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        we, req;
    logic [2:0]  sel;
    logic [31:0] rdata;
    logic [4:0]  exc;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [4:0]  exc;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    logic probe = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    int os_cnt [9]  = '{0, 0, 3, 2, 1, 0, 0, 0, 0};
    int ar_cnt [12] = '{0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0, 0};

    always #5 clk = ~clk;

    data_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .m_data_addr      (addr),
        .m_data_wdata     (wdata),
        .m_data_mem_write (we),
        .m_data_sel       (sel),
        .m_data_req       (req),
        .m_data_rdata     (rdata),
        .m_data_exc       (exc),
        .timer_irq        (irq)
    );

    always @(negedge clk) begin
        exp_t e;
        if (probe) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow: response with rdata=%h exc=%0d irq=%b but nothing expected",
                         rdata, exc, irq);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.rdata || exc !== e.exc || irq !== e.irq) begin
                    n_err++;
                    $display("FAIL %s: got rdata=%h exc=%0d irq=%b, expected rdata=%h exc=%0d irq=%b",
                             e.name, rdata, exc, irq, e.rdata, e.exc, e.irq);
                end
            end
        end
    end

    task automatic drv(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [2:0] s, input logic rq);
        addr  = a;
        wdata = wd;
        we    = w;
        sel   = s;
        req   = rq;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        probe = 1'b0;
        drv(32'd0, 32'd0, 1'b0, SEL_NONE, 1'b0);
    endtask

    task automatic expect_now(input string name, input logic [31:0] r,
                              input logic [4:0] x, input logic i);
        exp_t e;
        e.name  = name;
        e.rdata = r;
        e.exc   = x;
        e.irq   = i;
        sb.push_back(e);
        probe = 1'b1;
        step();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s);
        drv(a, wd, 1'b1, s, 1'b0);
        step();
    endtask

    task automatic load_chk(input string name, input logic [31:0] a, input logic [2:0] s,
                            input logic [31:0] r, input logic [4:0] x, input logic i);
        drv(a, 32'd0, 1'b0, s, 1'b0);
        expect_now(name, r, x, i);
    endtask

    task automatic store_chk(input string name, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] s, input logic [4:0] x, input logic i);
        drv(a, wd, 1'b1, s, 1'b0);
        expect_now(name, 32'd0, x, i);
    endtask

    initial begin
        reset = 1'b1;
        drv(32'd0, 32'd0, 1'b0, SEL_NONE, 1'b0);
        @(posedge clk);
        #1;
        load_chk("rst_ctrl",   A_CTRL, SEL_WORD, 32'd0, EXC_NONE, 1'b0);
        load_chk("rst_preset", A_PRE,  SEL_WORD, 32'd0, EXC_NONE, 1'b0);
        load_chk("rst_count",  A_CNT,  SEL_WORD, 32'd0, EXC_NONE, 1'b0);
        reset = 1'b0;

        // RAM lanes and extension
        store(32'h10, 32'h1234_5678, SEL_WORD);
        load_chk("lb_11",   32'h11, SEL_BYTE,  32'h0000_0056, EXC_NONE, 1'b0);
        load_chk("lh_12",   32'h12, SEL_HALF,  32'h0000_1234, EXC_NONE, 1'b0);
        load_chk("lw_10",   32'h10, SEL_WORD,  32'h1234_5678, EXC_NONE, 1'b0);
        store(32'h13, 32'h0000_0080, SEL_BYTE);
        load_chk("lbu_13",  32'h13, SEL_BYTEU, 32'h0000_0080, EXC_NONE, 1'b0);
        load_chk("lb_13",   32'h13, SEL_BYTE,  32'hFFFF_FF80, EXC_NONE, 1'b0);
        load_chk("lw_10b",  32'h10, SEL_WORD,  32'h8034_5678, EXC_NONE, 1'b0);
        store(32'h10, 32'hFFFF_C3A5, SEL_HALF);
        load_chk("lh_10",   32'h10, SEL_HALF,  32'hFFFF_C3A5, EXC_NONE, 1'b0);
        load_chk("lhu_10",  32'h10, SEL_HALFU, 32'h0000_C3A5, EXC_NONE, 1'b0);
        load_chk("lbu_12",  32'h12, SEL_BYTEU, 32'h0000_0034, EXC_NONE, 1'b0);

        // Decode exceptions
        store(32'h0, 32'h1111_1111, SEL_WORD);
        store_chk("sw_mis_2", 32'h2, 32'hDEAD_BEEF, SEL_WORD, EXC_ADES, 1'b0);
        load_chk("lw_0_kept", 32'h0, SEL_WORD, 32'h1111_1111, EXC_NONE, 1'b0);
        store(32'h2FFC, 32'h5A5A_5A5A, SEL_WORD);
        load_chk("lw_ram_top",  32'h2FFC, SEL_WORD, 32'h5A5A_5A5A, EXC_NONE, 1'b0);
        load_chk("lw_3000",     32'h3000, SEL_WORD, 32'd0, EXC_ADEL, 1'b0);
        load_chk("lh_timer",    A_CTRL,   SEL_HALF, 32'd0, EXC_ADEL, 1'b0);
        store_chk("sw_count",   A_CNT, 32'h0000_0009, SEL_WORD, EXC_ADES, 1'b0);
        load_chk("sel0_addr3",  32'h3, SEL_NONE, 32'd0, EXC_NONE, 1'b0);
        load_chk("sel6_addr3",  32'h3, 3'd6,     32'd0, EXC_NONE, 1'b0);
        load_chk("lw_mis_11",   32'h11, SEL_WORD, 32'd0, EXC_ADEL, 1'b0);
        load_chk("lh_mis_11",   32'h11, SEL_HALF, 32'd0, EXC_ADEL, 1'b0);
        load_chk("lw_7f0c",     32'h7F0C, SEL_WORD, 32'd0, EXC_ADEL, 1'b0);

        // Squashed store
        store(32'h20, 32'h0BAD_F00D, SEL_WORD);
        drv(32'h20, 32'hFFFF_FFFF, 1'b1, SEL_WORD, 1'b1);
        step();
        load_chk("lw_20_squash", 32'h20, SEL_WORD, 32'h0BAD_F00D, EXC_NONE, 1'b0);

        // One-shot timer: PRESET=3, CTRL=EN|IM
        store(A_PRE, 32'd3, SEL_WORD);
        load_chk("preset_rb", A_PRE, SEL_WORD, 32'd3, EXC_NONE, 1'b0);
        store(A_CTRL, 32'h9, SEL_WORD);
        for (int k = 0; k < 9; k++)
            load_chk($sformatf("os_k%0d", k), A_CNT, SEL_WORD, 32'(os_cnt[k]), EXC_NONE, k >= 7);
        load_chk("os_ctrl_en0", A_CTRL, SEL_WORD, 32'h8, EXC_NONE, 1'b1);
        store(A_PRE, 32'd3, SEL_WORD);
        load_chk("os_irq_clr", A_CTRL, SEL_WORD, 32'h8, EXC_NONE, 1'b0);

        // Auto-reload: PRESET=2, CTRL=EN|MODE01|IM
        store(A_PRE, 32'd2, SEL_WORD);
        store(A_CTRL, 32'hB, SEL_WORD);
        for (int k = 0; k < 12; k++)
            load_chk($sformatf("ar_k%0d", k), A_CNT, SEL_WORD, 32'(ar_cnt[k]), EXC_NONE, k >= 6);
        store(A_CTRL, 32'h0, SEL_WORD);
        load_chk("ar_off", A_CTRL, SEL_WORD, 32'h0, EXC_NONE, 1'b0);

        // Reset while COUNT=5
        store(A_PRE, 32'd8, SEL_WORD);
        store(A_CTRL, 32'h9, SEL_WORD);
        for (int k = 1; k < 5; k++) step();
        load_chk("mid_count6", A_CNT, SEL_WORD, 32'd6, EXC_NONE, 1'b0);
        reset = 1'b1;
        load_chk("mr_count", A_CNT,  SEL_WORD, 32'd0, EXC_NONE, 1'b0);
        load_chk("mr_ctrl",  A_CTRL, SEL_WORD, 32'd0, EXC_NONE, 1'b0);
        load_chk("mr_pre",   A_PRE,  SEL_WORD, 32'd0, EXC_NONE, 1'b0);
        drv(A_PRE, 32'h77, 1'b1, SEL_WORD, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        step();
        load_chk("rel_store", A_PRE, SEL_WORD, 32'h77, EXC_NONE, 1'b0);
        for (int k = 0; k < 12; k++)
            load_chk($sformatf("post_rst_k%0d", k), A_CNT, SEL_WORD, 32'd0, EXC_NONE, 1'b0);

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected responses left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_bridge.md
# data_bridge

Responder end of the CPU data-memory port. It decodes each M-stage access into on-chip data RAM or a memory-mapped countdown timer, and applies byte-lane steering and load extension. It also generates the address-exception code that the CPU merges into the M stage. The timer interrupt output feeds `hw_int[0]`.

## Interface
- `DM_WORDS`, 3072: data RAM depth in 32-bit words; byte range 0x0000_0000 up to 4·DM_WORDS−1.
- `TIMER_BASE`, 32'h0000_7F00: timer window base; 12 bytes.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `m_data_addr` in 32: byte address, M stage.
- `m_data_wdata` in 32: store data, right-aligned (low byte/half).
- `m_data_mem_write` in 1: store request.
- `m_data_sel` in 3: 0 none, 1 word, 2 half signed, 3 half unsigned, 4 byte signed, 5 byte unsigned; 6,7 treated as none. Stores use 1/2/4.
- `m_data_req` in 1: CPU taking an interrupt/exception this cycle; M-stage access is squashed.
- `m_data_rdata` out 32: load result, already extended.
- `m_data_exc` out 5: 0 none, 4 AdEL, 5 AdES.
- `timer_irq` out 1: level interrupt.

## Operation
- Decode (combinational, only when sel∈1..5):
  - misaligned (word addr[1:0]≠0, half addr[0]≠0);
  - address outside RAM and timer windows;
  - non-word access to the timer;
  - store to COUNT.
  - Any decode failure raises exc = AdES if `m_data_mem_write` is high, else AdEL.
- Store commit at rising edge iff mem_write & exc==0 & !m_data_req. Stores are never partially performed.
- RAM stores:
  - word: all lanes.
  - half: lane pair addr[1], data = wdata[15:0].
  - byte: lane addr[1:0], data = wdata[7:0].
- Loads: rdata = lane select plus sign/zero extension per sel. Data is returned when exc==0; otherwise rdata = 0. RAM read is asynchronous.
- Timer registers:
  - CTRL @+0: bits [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x behaves as 00), [3] IM; other bits read 0.
  - PRESET @+4: R/W.
  - COUNT @+8: read-only.
- Timer FSM states IDLE, LOAD, CNT, INT:
  - IDLE→LOAD when EN.
  - LOAD: COUNT←PRESET, →CNT.
  - CNT: if !EN →IDLE; else if COUNT==0 →INT; else COUNT−1.
  - INT: pending←1. One-shot: EN←0, →IDLE. Auto-reload: →LOAD.
- `timer_irq` = pending & IM. pending is cleared by any committed write to CTRL or PRESET.
- Simultaneous events:
  - A committed CTRL write and an FSM EN-clear in the same cycle: the CPU write wins.
  - A pending clear and an INT set in the same cycle: the set wins.

## Timing
- Load: zero latency. rdata/exc are valid in the same cycle as the address; the CPU samples into W at the next edge.
- Store: visible to a load in the following cycle.
- Timer, from a committed CTRL write setting EN with PRESET=N:
  - edge+1 IDLE→LOAD;
  - +2 COUNT=N;
  - then N decrement cycles;
  - INT entered N+3 edges after the write;
  - `timer_irq` high from edge N+4 if IM.
- PRESET=0 reaches INT 3 edges after the write.
- Reset (async, any time): FSM IDLE, CTRL=PRESET=COUNT=0, pending=0, `timer_irq`=0. RAM contents are not reset. `m_data_rdata`/`m_data_exc` follow inputs combinationally (0 for sel=0).
- Reset mid-count: aborts immediately; no interrupt.

## Structure
- Shared package `bridge_pkg`:
  - EXC_NONE/EXC_ADEL/EXC_ADES;
  - the sel encodings;
  - timer register offsets;
  - timer state enum.
- The CPU must use the same sel and ExcCode constants.
- Sub-module `bridge_timer` holds the FSM, registers and IRQ. `data_bridge` holds the decode, lanes, RAM and read mux.

## Test plan
- sw 0x1234_5678 @0x10; lb @0x11 → 0x0000_0056. lh @0x12 → 0x0000_1234. lbu after sb 0x80 @0x13 → 0x0000_0080, lb → 0xFFFF_FF80.
- sw @0x2 → exc=5, RAM unchanged. lw @0x3000 → exc=4. lh @0x7F00 → exc=4. sw @0x7F08 → exc=5. sel=0 with addr 0x3 → exc=0.
- sw with m_data_req=1 @0x20 → later lw @0x20 returns the old value.
- PRESET=3, then CTRL=0x9 (one-shot, IM) → `timer_irq` rises 7 edges after the CTRL write. EN then reads 0. Write PRESET → irq drops next cycle.
- CTRL=0xB (auto-reload) with PRESET=2 → INT recurs every 5 cycles, COUNT sequence 2,1,0.
- Assert reset while COUNT=5 → all timer registers read 0 and irq never fires. Store at the same edge as reset release is committed normally.
